ex_mem_stage: RTL

//  Execute-stage condition unit plus Execute->Memory pipeline register. Consumes the E-stage

---
 rtl/arm_pipe_pkg.sv | 19 +
 rtl/cond_check.sv | 40 ++++
 rtl/ex_mem_stage.sv | 93 +++++++++
 3 files changed

// File: rtl/arm_pipe_pkg.sv
// Shared pipeline definitions: ARM condition codes, NZCV bit positions and flag-write masks.
package arm_pipe_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_t;

  localparam int unsigned N_IDX = 3;
  localparam int unsigned Z_IDX = 2;
  localparam int unsigned C_IDX = 1;
  localparam int unsigned V_IDX = 0;

  localparam logic [1:0] FW_NZ = 2'b10;
  localparam logic [1:0] FW_CV = 2'b01;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluation of CondE against the architectural NZCV register.
module cond_check
  import arm_pipe_pkg::*;
(
  input  logic [3:0] CondE,
  input  logic [3:0] FlagsQ,
  output logic       CondExE
);

  logic n, z, c, v;

  assign n = FlagsQ[N_IDX];
  assign z = FlagsQ[Z_IDX];
  assign c = FlagsQ[C_IDX];
  assign v = FlagsQ[V_IDX];

  // NV is executed unconditionally, same as AL.
  always_comb begin
    CondExE = 1'b1;
    case (cond_t'(CondE))
      COND_EQ: CondExE = z;
      COND_NE: CondExE = ~z;
      COND_CS: CondExE = c;
      COND_CC: CondExE = ~c;
      COND_MI: CondExE = n;
      COND_PL: CondExE = ~n;
      COND_VS: CondExE = v;
      COND_VC: CondExE = ~v;
      COND_HI: CondExE = c & ~z;
      COND_LS: CondExE = ~c | z;
      COND_GE: CondExE = (n == v);
      COND_LT: CondExE = (n != v);
      COND_GT: CondExE = ~z & (n == v);
      COND_LE: CondExE = z | (n != v);
      COND_AL: CondExE = 1'b1;
      COND_NV: CondExE = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute condition gating, NZCV register and Execute->Memory pipeline register.
// Optional squashed-instruction counter enabled by defining EXMEM_SQUASH_CNT_EN.
module ex_mem_stage
  import arm_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              EnM,
  input  logic              FlushM,
  input  logic              PCSrcE,
  input  logic              RegWriteE,
  input  logic              MemtoRegE,
  input  logic              MemWriteE,
  input  logic [1:0]        FlagWriteE,
  input  logic [3:0]        CondE,
  input  logic [3:0]        ALUFlagsE,
  input  logic [DATA_W-1:0] ALUResultE,
  input  logic [DATA_W-1:0] WriteDataE,
  input  logic [REG_AW-1:0] WA3E,
  output logic              CondExE,
  output logic              PCSrcGateE,
  output logic [3:0]        FlagsQ,
  output logic              PCSrcM,
  output logic              RegWriteM,
  output logic              MemtoRegM,
  output logic              MemWriteM,
  output logic [DATA_W-1:0] ALUResultM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [REG_AW-1:0] WA3M
`ifdef EXMEM_SQUASH_CNT_EN
  ,
  output logic [15:0]       SquashCnt
`endif
);

  logic wr_nz, wr_cv;

  cond_check u_cond_check (
    .CondE   (CondE),
    .FlagsQ  (FlagsQ),
    .CondExE (CondExE)
  );

  assign PCSrcGateE = PCSrcE & CondExE;
  assign wr_nz      = |(FlagWriteE & FW_NZ) & CondExE;
  assign wr_cv      = |(FlagWriteE & FW_CV) & CondExE;

  always_ff @(posedge clk) begin
    if (!reset) begin
      PCSrcM     <= 1'b0;
      RegWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      WA3M       <= '0;
      FlagsQ     <= '0;
    end else if (FlushM) begin
      // Bubble: controls cleared, data and flags left as they were.
      PCSrcM    <= 1'b0;
      RegWriteM <= 1'b0;
      MemtoRegM <= 1'b0;
      MemWriteM <= 1'b0;
    end else if (EnM) begin
      PCSrcM     <= PCSrcGateE;
      RegWriteM  <= RegWriteE & CondExE;
      MemtoRegM  <= MemtoRegE;
      MemWriteM  <= MemWriteE & CondExE;
      ALUResultM <= ALUResultE;
      WriteDataM <= WriteDataE;
      WA3M       <= WA3E;
      if (wr_nz) FlagsQ[N_IDX:Z_IDX] <= ALUFlagsE[N_IDX:Z_IDX];
      if (wr_cv) FlagsQ[C_IDX:V_IDX] <= ALUFlagsE[C_IDX:V_IDX];
    end
  end

`ifdef EXMEM_SQUASH_CNT_EN
  logic squash;

  assign squash = ~CondExE & (PCSrcE | RegWriteE | MemWriteE | (|FlagWriteE));

  always_ff @(posedge clk) begin
    if (!reset)
      SquashCnt <= '0;
    else if (!FlushM && EnM && squash)
      SquashCnt <= SquashCnt + 16'd1;
  end
`endif

endmodule
